// File: rtl/riscv_pkg.sv
// Shared definitions for the commit tracer: halt encodings, FSM states, trace entry layout.
// Pure types and constants, no logic.
package riscv_pkg;

  localparam logic [31:0] INSTR_EBREAK   = 32'h00100073;
  localparam logic [31:0] INSTR_SELF_JAL = 32'h0000006f;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } trace_ent_t;

  function automatic logic is_halt(input logic [31:0] instr);
    return (instr == INSTR_EBREAK) || (instr == INSTR_SELF_JAL);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO, 1-cycle push-to-visible (no fall-through), head presented combinationally.
// Push while full is dropped unless a pop happens the same cycle; pop while empty is a no-op.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/riscv_commit_tracer.sv
// Writeback observer: queues retirements, counts cycles/retires, halts on EBREAK or jal x0,0.
// Trace visible 1 cycle after retire; consumer stalls via trace_ready, overflow drops are flagged.
module riscv_commit_tracer
  import riscv_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int MAX_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_instr,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_rd,
  output logic [31:0] trace_data,
  output logic [31:0] cycle_count,
  output logic [31:0] retire_count,
  output logic        halted,
  output logic        timeout,
  output logic        overflow
);

  state_t     state_q, state_d;
  logic       accept;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  trace_ent_t ent_in;
  trace_ent_t ent_out;

  assign ent_in.pc   = wb_pc;
  assign ent_in.rd   = wb_we ? wb_rd : 5'd0;
  assign ent_in.data = wb_we ? wb_data : 32'd0;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_ent_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (ent_in),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (ent_out),
    .empty (fifo_empty)
  );

  // Head is masked to zero while empty so the idle/reset bus reads all-zero.
  assign trace_valid = !fifo_empty;
  assign pop         = trace_valid && trace_ready;
  assign trace_pc    = fifo_empty ? 32'd0 : ent_out.pc;
  assign trace_rd    = fifo_empty ? 5'd0  : ent_out.rd;
  assign trace_data  = fifo_empty ? 32'd0 : ent_out.data;
  assign halted      = (state_q == ST_HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_RUN: begin
        accept = wb_valid;
        if (wb_valid && is_halt(wb_instr)) state_d = ST_DRAIN;
      end
      // No pushes happen in DRAIN, so an empty FIFO here is final.
      ST_DRAIN: if (fifo_empty) state_d = ST_HALTED;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count  <= 32'd0;
      retire_count <= 32'd0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (accept) retire_count <= retire_count + 32'd1;
      if (accept && fifo_full && !pop) overflow <= 1'b1;
      if (state_q != ST_HALTED) begin
        cycle_count <= cycle_count + 32'd1;
        if (cycle_count == 32'(MAX_CYCLES - 1)) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_commit_tracer.sv
// Self-checking bench for riscv_commit_tracer: vector table plus scoreboard on the trace port.
`timescale 1ns/1ps
module tb_riscv_commit_tracer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_instr;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;
  logic        halted;
  logic        timeout;
  logic        overflow;

  riscv_commit_tracer #(.DEPTH(8), .MAX_CYCLES(50)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_pc        (wb_pc),
    .wb_instr     (wb_instr),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_pc     (trace_pc),
    .trace_rd     (trace_rd),
    .trace_data   (trace_data),
    .cycle_count  (cycle_count),
    .retire_count (retire_count),
    .halted       (halted),
    .timeout      (timeout),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  localparam logic [31:0] NOP = 32'h00000013;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   popped   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                       input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_instr = instr;
    wb_we    = we;
    wb_rd    = rd;
    wb_data  = data;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.pc = pc; e.rd = rd; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1; wb_valid = 1'b0; trace_ready = 1'b0;
    wb_pc = '0; wb_instr = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    step();
    step();
    exp_q.delete();
    popped = 0;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) step();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: a pop happens at the next edge whenever valid && ready at the falling edge.
  always @(negedge clk) begin
    if (!reset && trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_entry: got pc %h expected no entry", trace_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("trace_pc", trace_pc, e.pc);
        check("trace_rd", 32'(trace_rd), 32'(e.rd));
        check("trace_data", trace_data, e.data);
        popped++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  vec_t vecs[5];
  logic [31:0] cc_snap;

  initial begin
    vecs[0] = '{32'h0,  32'h00500093, 1'b1, 5'd1,  32'd5,        5'd1,  32'd5};
    vecs[1] = '{32'h4,  32'h00700113, 1'b1, 5'd2,  32'd7,        5'd2,  32'd7};
    vecs[2] = '{32'h8,  32'h0020a023, 1'b0, 5'd4,  32'hdead,     5'd0,  32'd0};
    vecs[3] = '{32'hc,  32'hfff00f93, 1'b1, 5'd31, 32'hffffffff, 5'd31, 32'hffffffff};
    vecs[4] = '{32'h10, 32'h00000463, 1'b0, 5'd8,  32'h1234,     5'd0,  32'd0};

    // Power-on reset values
    do_reset();
    check("rst_valid", 32'(trace_valid), 32'd0);
    check("rst_pc", trace_pc, 32'd0);
    check("rst_cycles", cycle_count, 32'd0);
    check("rst_retires", retire_count, 32'd0);
    check("rst_flags", {29'd0, halted, timeout, overflow}, 32'd0);

    // Reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(32'h40 + 32'(i * 4), NOP, 1'b1, 5'(i + 1), 32'(i));
      step();
    end
    wb_valid = 1'b0;
    check("mid_retires", retire_count, 32'd3);
    check("mid_valid", 32'(trace_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(trace_valid), 32'd0);
    check("async_retires", retire_count, 32'd0);
    step();
    step();
    reset = 1'b0;
    check("mid_cycles", cycle_count, 32'd0);
    check("mid_flags", {29'd0, halted, timeout, overflow}, 32'd0);
    trace_ready = 1'b1;
    drive(32'h80, NOP, 1'b1, 5'd3, 32'h33);
    expect_entry(32'h80, 5'd3, 32'h33);
    step();
    wb_valid = 1'b0;
    check("post_rst_run", retire_count, 32'd1);
    wait_drain("post_rst_drain");

    // Table-driven retirements through the trace port
    do_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].pc, vecs[i].instr, vecs[i].we, vecs[i].rd, vecs[i].data);
      expect_entry(vecs[i].pc, vecs[i].exp_rd, vecs[i].exp_data);
      step();
    end
    wb_valid = 1'b0;
    check("tbl_retires", retire_count, 32'd5);
    wait_drain("tbl_drain");
    check("tbl_popped", 32'(popped), 32'd5);

    // Overflow: 10 retirements into 8 entries with consumer stalled
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(32'h100 + 32'(i * 4), NOP, 1'b1, 5'(i + 1), 32'(i * 11));
      if (i < 8) expect_entry(32'h100 + 32'(i * 4), 5'(i + 1), 32'(i * 11));
      step();
    end
    wb_valid = 1'b0;
    step();
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_retires", retire_count, 32'd10);
    check("ovf_head_stable", trace_pc, 32'h100);
    drive(32'h200, NOP, 1'b1, 5'd9, 32'h99);
    expect_entry(32'h200, 5'd9, 32'h99);
    trace_ready = 1'b1;
    step();
    wb_valid = 1'b0;
    check("full_push_pop_retires", retire_count, 32'd11);
    wait_drain("ovf_drain");
    check("ovf_popped", 32'(popped), 32'd9);

    // EBREAK with two entries queued and retirements continuing afterwards
    do_reset();
    drive(32'h18, NOP, 1'b1, 5'd5, 32'h18);
    expect_entry(32'h18, 5'd5, 32'h18);
    step();
    drive(32'h1c, NOP, 1'b1, 5'd6, 32'h1c);
    expect_entry(32'h1c, 5'd6, 32'h1c);
    step();
    drive(32'h20, 32'h00100073, 1'b0, 5'd0, 32'h0);
    expect_entry(32'h20, 5'd0, 32'd0);
    step();
    drive(32'h24, NOP, 1'b1, 5'd7, 32'h77);
    trace_ready = 1'b1;
    for (int k = 0; k < 40 && !halted; k++) step();
    check("ebreak_halted", 32'(halted), 32'd1);
    check("ebreak_queue", 32'(exp_q.size()), 32'd0);
    check("ebreak_retires", retire_count, 32'd3);
    cc_snap = cycle_count;
    for (int k = 0; k < 4; k++) begin
      wb_valid = k[0];
      step();
    end
    check("halt_cycles_frozen", cycle_count, cc_snap);
    check("halt_retires", retire_count, 32'd3);
    check("halt_valid", 32'(trace_valid), 32'd0);
    check("halt_sticky", 32'(halted), 32'd1);
    wb_valid = 1'b0;

    // Timeout at MAX_CYCLES=50 without a halt
    do_reset();
    trace_ready = 1'b1;
    for (int i = 1; i <= 55; i++) begin
      step();
      if (i == 49) begin
        check("to_before", 32'(timeout), 32'd0);
        check("to_cc49", cycle_count, 32'd49);
      end
      if (i == 50) check("to_at50", 32'(timeout), 32'd1);
    end
    check("to_sticky", 32'(timeout), 32'd1);
    check("to_counting", cycle_count, 32'd55);
    check("to_not_halted", 32'(halted), 32'd0);

    // jal x0,0 into an empty FIFO with ready held: halted two cycles later
    do_reset();
    trace_ready = 1'b1;
    drive(32'h40, 32'h0000006f, 1'b0, 5'd0, 32'h0);
    expect_entry(32'h40, 5'd0, 32'd0);
    step();
    wb_valid = 1'b0;
    check("jal_visible", 32'(trace_valid), 32'd1);
    check("jal_h0", 32'(halted), 32'd0);
    step();
    check("jal_h1", 32'(halted), 32'd0);
    step();
    check("jal_h2", 32'(halted), 32'd1);
    check("jal_queue", 32'(exp_q.size()), 32'd0);
    check("jal_retires", retire_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_commit_tracer.md
# riscv_commit_tracer

Synthesizable observer on the writeback end of the pipelined RISC-V core. It captures every retired instruction into a small trace FIFO, counts cycles and retirements, and detects the program-end condition (EBREAK or a `jal x0,0` self-loop). Halt, timeout and overflow are reported as status outputs. The simulation bench drains the FIFO and stops on `halted` instead of running for a fixed delay.

## Interface
Parameters:
- DEPTH, 8: trace FIFO entries. Must be a power of two, ≥2.
- MAX_CYCLES, 1000: cycle count at which `timeout` asserts.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wb_valid  in  1  an instruction retires this cycle.
- wb_pc  in  32  PC of the retiring instruction.
- wb_instr  in  32  encoding of the retiring instruction.
- wb_we  in  1  the retiring instruction writes the register file.
- wb_rd  in  5  destination register.
- wb_data  in  32  writeback value.
- trace_valid  out  1  the FIFO head entry is presented.
- trace_ready  in  1  consumer accepts the head entry.
- trace_pc  out  32  head entry PC.
- trace_rd  out  5  head entry rd; forced to 0 when the entry had no register write.
- trace_data  out  32  head entry data; forced to 0 when the entry had no register write.
- cycle_count  out  32  cycles since reset, excluding the HALTED state.
- retire_count  out  32  accepted retirements.
- halted  out  1  halt instruction retired and FIFO fully drained.
- timeout  out  1  sticky; cycle_count reached MAX_CYCLES.
- overflow  out  1  sticky; a retirement was dropped because the FIFO was full.

## Operation
- The FSM has three states: RUN, DRAIN, HALTED. Reset enters RUN.
- RUN: each `wb_valid` cycle is one retirement.
  - retire_count increments.
  - An entry {pc, we?rd:0, we?data:0} is pushed.
- Halt match: `wb_instr == 32'h00100073` (EBREAK) or `32'h0000006f` (jal x0,0), with `wb_valid` high.
  - The halting instruction is itself counted and pushed.
  - The FSM then goes to DRAIN.
- DRAIN: `wb_valid` is ignored (no count, no push). Go to HALTED on the first cycle the FIFO is empty after any pop that cycle.
- HALTED: terminal state; only reset leaves it. `wb_valid` is ignored. The FIFO stays empty.
- Counters wrap modulo 2^32. cycle_count increments every cycle in RUN and DRAIN.
- timeout sets when cycle_count == MAX_CYCLES−1 and it increments. It is independent of the FSM and does not stop counting.
- FIFO boundary rules:
  - Full, push, no pop: the push is dropped, overflow sets, retire_count still increments.
  - Full, push and pop in the same cycle: both are accepted.
  - Empty, push: the entry is visible next cycle; there is no fall-through.
  - Pop = trace_valid && trace_ready. Pop while empty is a no-op.
- Pointers are log2(DEPTH)+1 bits wide. Full/empty come from the MSB compare, so wrap-around needs no separate occupancy counter.

## Timing
- Reset values:
  - All outputs are 0: trace_valid=0, trace_pc/rd/data=0, counters=0, halted=0, timeout=0, overflow=0.
  - FIFO pointers are 0 and the state is RUN.
- Push-to-visible latency: 1 cycle. A retirement at edge N gives trace_valid=1 after edge N.
- trace_pc/rd/data must remain stable while trace_valid=1 and trace_ready=0.
- halted asserts one edge after the cycle in which the state becomes HALTED.
  - Best case, halt retires into an empty FIFO with trace_ready held high: halted asserts 2 cycles after the halt retirement.
- Reset asserted mid-operation: everything clears asynchronously, including a half-drained FIFO and sticky flags. The first edge after deassertion runs in RUN.

## Structure
- Shared package `riscv_pkg` holds:
  - `INSTR_EBREAK = 32'h00100073`
  - `INSTR_SELF_JAL = 32'h0000006f`
  - the FSM state enum {ST_RUN, ST_DRAIN, ST_HALTED}
  - the trace entry struct {pc[31:0], rd[4:0], data[31:0]}, 69 bits
- One sub-module is natural: `trace_fifo`. It is a synchronous FIFO with parameter DEPTH and WIDTH=69, and ports push/din/full/pop/dout/empty. The counters and FSM stay in the top.

## Test plan
- Reset mid-stream: push 3 entries, assert reset for 2 cycles → trace_valid=0, counters=0, flags=0, FSM in RUN.
- Three retirements (pc 0x0/0x4/0x8; x1=5, x2=7, store with we=0), trace_ready=1 → three entries in order; the third reads rd=0, data=0; retire_count=3.
- DEPTH=8, trace_ready=0, 10 retirements → first 8 entries kept, overflow=1, retire_count=10. Then assert ready with a simultaneous push while full → both accepted, count stays at 8.
- EBREAK at pc 0x20 with 2 entries queued, ready=1, further wb_valid afterwards → EBREAK entry is popped last, later retirements are not counted, halted=1, cycle_count frozen from then on.
- MAX_CYCLES=50, no halt instruction → timeout=1 exactly after the 50th edge post-reset; halted stays 0.
- `jal x0,0` (0x0000006f) retiring with an empty FIFO and ready=1 → halted=1 two cycles later.
